// File: rtl/partchk_pkg.sv
// Shared definitions for the partition exhaustive checker: FSM state
// encoding, result-width helper and a popcount used by the error accumulator.
package partchk_pkg;

    // FSM state set (IDLE, HOLD, SAMPLE, DONE), encoded as plain 2-bit constants.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_HOLD   = 2'd1;
    localparam state_t ST_SAMPLE = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    // Width of the bit-flip accumulator: 2^num_pi vectors, each with up to num_po flips.
    function automatic int errbit_w(input int num_pi, input int num_po);
        return num_pi + $clog2(num_po + 1);
    endfunction

    // Population count over up to 32 bits; callers zero-extend narrower buses.
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/partchk_err_acc.sv
// Per-vector compare of exact vs approximate outputs and the error-metric
// accumulators. Optional first-failure capture when PARTCHK_FIRST_FAIL_EN is defined.
module partchk_err_acc
    import partchk_pkg::*;
#(
    parameter int NUM_PI = 7,
    parameter int NUM_PO = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clr,
    input  logic                                  en,
    input  logic [NUM_PI-1:0]                     vec,
    input  logic [NUM_PO-1:0]                     po_exact,
    input  logic [NUM_PO-1:0]                     po_approx,
    output logic [NUM_PI:0]                       err_vec_cnt,
    output logic [errbit_w(NUM_PI, NUM_PO)-1:0]   err_bit_cnt,
    output logic [NUM_PO-1:0]                     max_abs_err
`ifdef PARTCHK_FIRST_FAIL_EN
    ,
    output logic                                  first_fail_valid,
    output logic [NUM_PI-1:0]                     first_fail_vec,
    output logic [NUM_PO-1:0]                     first_fail_po
`endif
);

    localparam int BW = errbit_w(NUM_PI, NUM_PO);

    logic [NUM_PO-1:0] diff_bits;
    logic              mismatch;
    logic [NUM_PO:0]   sub;
    logic [NUM_PO:0]   abs_full;
    logic [NUM_PO-1:0] abs_err;
    logic [5:0]        flips;

    // Difference taken one bit wider so the sign is visible; magnitude always fits NUM_PO bits.
    always_comb begin
        diff_bits = po_exact ^ po_approx;
        mismatch  = |diff_bits;
        sub       = {1'b0, po_exact} - {1'b0, po_approx};
        abs_full  = sub[NUM_PO] ? (~sub + {{NUM_PO{1'b0}}, 1'b1}) : sub;
        abs_err   = abs_full[NUM_PO-1:0];
        flips     = popcount(32'(diff_bits));
    end

    // Accumulators: cleared on sweep start, updated once per SAMPLE strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_vec_cnt <= '0;
            err_bit_cnt <= '0;
            max_abs_err <= '0;
        end else if (clr) begin
            err_vec_cnt <= '0;
            err_bit_cnt <= '0;
            max_abs_err <= '0;
        end else if (en) begin
            err_vec_cnt <= err_vec_cnt + (NUM_PI+1)'(mismatch);
            err_bit_cnt <= err_bit_cnt + BW'(flips);
            if (abs_err > max_abs_err) max_abs_err <= abs_err;
        end
    end

`ifdef PARTCHK_FIRST_FAIL_EN
    // Latch the first mismatching vector of the sweep and hold it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_po    <= '0;
        end else if (clr) begin
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_po    <= '0;
        end else if (en && mismatch && !first_fail_valid) begin
            first_fail_valid <= 1'b1;
            first_fail_vec   <= vec;
            first_fail_po    <= po_approx;
        end
    end
`endif

endmodule

// File: rtl/partition_exhaustive_checker.sv
// Exhaustive-stimulus error checker for one partition: walks every NUM_PI-bit
// vector, holds each SETTLE cycles, then samples and accumulates error metrics.
// Optional first-failure outputs are enabled by PARTCHK_FIRST_FAIL_EN.
module partition_exhaustive_checker
    import partchk_pkg::*;
#(
    parameter int NUM_PI = 7,
    parameter int NUM_PO = 4,
    parameter int SETTLE = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  abort,
    output logic [NUM_PI-1:0]                     pi_out,
    input  logic [NUM_PO-1:0]                     po_exact,
    input  logic [NUM_PO-1:0]                     po_approx,
    output logic                                  busy,
    output logic                                  done,
    output logic [NUM_PI:0]                       err_vec_cnt,
    output logic [errbit_w(NUM_PI, NUM_PO)-1:0]   err_bit_cnt,
    output logic [NUM_PO-1:0]                     max_abs_err
`ifdef PARTCHK_FIRST_FAIL_EN
    ,
    output logic                                  first_fail_valid,
    output logic [NUM_PI-1:0]                     first_fail_vec,
    output logic [NUM_PO-1:0]                     first_fail_po
`endif
);

    state_t            state;
    logic [NUM_PI-1:0] vec;
    logic [3:0]        settle_cnt;
    logic              idle_or_done;
    logic              acc_clr;
    logic              acc_en;

    // Start is only honoured when no sweep is running; abort outranks the sample update.
    always_comb begin
        idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
        acc_clr      = idle_or_done && start;
        acc_en       = (state == ST_SAMPLE) && !abort;
    end

    assign pi_out = vec;

    // Sweep FSM with vector and settle counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        vec        <= '0;
                        settle_cnt <= '0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (settle_cnt == 4'(SETTLE - 1)) begin
                        settle_cnt <= '0;
                        state      <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (&vec) begin
                        // Terminal vector: pi_out stays on all-ones.
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        vec   <= vec + {{(NUM_PI-1){1'b0}}, 1'b1};
                        state <= ST_HOLD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    partchk_err_acc #(
        .NUM_PI (NUM_PI),
        .NUM_PO (NUM_PO)
    ) u_acc (
        .clk              (clk),
        .rst_n            (rst_n),
        .clr              (acc_clr),
        .en               (acc_en),
        .vec              (vec),
        .po_exact         (po_exact),
        .po_approx        (po_approx),
        .err_vec_cnt      (err_vec_cnt),
        .err_bit_cnt      (err_bit_cnt),
        .max_abs_err      (max_abs_err)
`ifdef PARTCHK_FIRST_FAIL_EN
        ,
        .first_fail_valid (first_fail_valid),
        .first_fail_vec   (first_fail_vec),
        .first_fail_po    (first_fail_po)
`endif
    );

endmodule

// File: tb/tb_partition_exhaustive_checker.sv
// Directed bench for partition_exhaustive_checker: a 7-in/4-out instance driven
// by table-driven sweeps plus start/abort/reset sequences, and a 3-in/2-out
// SETTLE=3 instance for the vector-timing case.
module tb_partition_exhaustive_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, abort;
    logic [6:0] pi_out;
    logic [3:0] po_exact, po_approx;
    logic       busy, done;
    logic [7:0] evc;
    logic [9:0] ebc;
    logic [3:0] mae;
    int         mode;

    logic       s_start, s_abort;
    logic [2:0] s_pi;
    logic [1:0] s_exact, s_approx;
    logic       s_busy, s_done;
    logic [3:0] s_evc;
    logic [4:0] s_ebc;
    logic [1:0] s_mae;

`ifdef PARTCHK_FIRST_FAIL_EN
    logic       ffv, s_ffv;
    logic [6:0] ffvec;
    logic [3:0] ffpo;
    logic [2:0] s_ffvec;
    logic [1:0] s_ffpo;
`endif

    // Partition models: mode 0 exact copy of a 3+4 bit adder, mode 1 LSB flipped,
    // mode 2 single-vector failure at 7'h55.
    always_comb begin
        po_exact  = 4'(pi_out[6:4]) + pi_out[3:0];
        po_approx = po_exact;
        case (mode)
            1: po_approx = po_exact ^ 4'b0001;
            2: begin
                po_exact  = (pi_out == 7'h55) ? 4'hF : 4'h0;
                po_approx = 4'h0;
            end
            default: ;
        endcase
    end

    assign s_exact  = s_pi[1:0];
    assign s_approx = 2'b11;

    partition_exhaustive_checker #(.NUM_PI(7), .NUM_PO(4), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pi_out(pi_out),
        .po_exact(po_exact), .po_approx(po_approx), .busy(busy), .done(done),
        .err_vec_cnt(evc), .err_bit_cnt(ebc), .max_abs_err(mae)
`ifdef PARTCHK_FIRST_FAIL_EN
        , .first_fail_valid(ffv), .first_fail_vec(ffvec), .first_fail_po(ffpo)
`endif
    );

    partition_exhaustive_checker #(.NUM_PI(3), .NUM_PO(2), .SETTLE(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort), .pi_out(s_pi),
        .po_exact(s_exact), .po_approx(s_approx), .busy(s_busy), .done(s_done),
        .err_vec_cnt(s_evc), .err_bit_cnt(s_ebc), .max_abs_err(s_mae)
`ifdef PARTCHK_FIRST_FAIL_EN
        , .first_fail_valid(s_ffv), .first_fail_vec(s_ffvec), .first_fail_po(s_ffpo)
`endif
    );

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Count posedges from start acceptance until done is seen (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_pi(input int v, input string name);
        int n;
        n = 0;
        while (pi_out != 7'(v) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(pi_out), 64'(v));
    endtask

    typedef struct {
        int mode;
        int cyc;
        int evc;
        int ebc;
        int mae;
        int ffv;
        int ffvec;
        int ffpo;
    } vec_t;

    vec_t tbl[3];

    initial begin
        int cyc, bad;
        tbl[0] = '{0, 256, 0,   0,   0,  0, 0,    0};
        tbl[1] = '{1, 256, 128, 128, 1,  1, 0,    1};
        tbl[2] = '{2, 256, 1,   4,   15, 1, 'h55, 0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0;
        s_start = 1'b0; s_abort = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pi", 64'(pi_out), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_cnts", 64'({evc, ebc, mae}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven full sweeps
        foreach (tbl[i]) begin
            mode = tbl[i].mode;
            pulse_start();
            check($sformatf("t%0d_busy", i), 64'(busy), 1);
            wait_done(cyc);
            check($sformatf("t%0d_cycles", i), 64'(cyc), 64'(tbl[i].cyc));
            check($sformatf("t%0d_evc", i), 64'(evc), 64'(tbl[i].evc));
            check($sformatf("t%0d_ebc", i), 64'(ebc), 64'(tbl[i].ebc));
            check($sformatf("t%0d_mae", i), 64'(mae), 64'(tbl[i].mae));
            check($sformatf("t%0d_pi_final", i), 64'(pi_out), 64'h7f);
            check($sformatf("t%0d_busy_end", i), 64'(busy), 0);
`ifdef PARTCHK_FIRST_FAIL_EN
            check($sformatf("t%0d_ffv", i), 64'(ffv), 64'(tbl[i].ffv));
            if (tbl[i].ffv != 0) begin
                check($sformatf("t%0d_ffvec", i), 64'(ffvec), 64'(tbl[i].ffvec));
                check($sformatf("t%0d_ffpo", i), 64'(ffpo), 64'(tbl[i].ffpo));
            end
`endif
        end

        // Results held in DONE; abort there has no effect
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("done_hold", 64'(done), 1);
        check("done_hold_evc", 64'(evc), 1);

        // start while busy ignored, then abort at pi_out=40
        mode = 1;
        pulse_start();
        wait_pi(10, "t4_reach10");
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("t4_start_ignored_pi", 64'(pi_out), 10);
        check("t4_still_busy", 64'(busy), 1);
        wait_pi(40, "t4_reach40");
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        check("t4_abort_busy", 64'(busy), 0);
        check("t4_abort_done", 64'(done), 0);
        check("t4_abort_evc", 64'(evc), 40);
        check("t4_abort_ebc", 64'(ebc), 40);
        repeat (5) @(negedge clk);
        check("t4_frozen_evc", 64'(evc), 40);
        check("t4_frozen_mae", 64'(mae), 1);
        pulse_start();
        check("t4_restart_pi", 64'(pi_out), 0);
        check("t4_restart_evc", 64'(evc), 0);
        check("t4_restart_busy", 64'(busy), 1);
        wait_done(cyc);
        check("t4_rerun_cycles", 64'(cyc), 256);
        check("t4_rerun_evc", 64'(evc), 128);

        // Async reset during SAMPLE
        pulse_start();
        wait_pi(5, "t5_reach5");
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_async_pi", 64'(pi_out), 0);
        check("t5_async_busy", 64'(busy), 0);
        check("t5_async_cnts", 64'({evc, ebc, mae, done}), 0);
        @(negedge clk) rst_n = 1'b1;
        mode = 2;
        pulse_start();
        wait_done(cyc);
        check("t5_clean_cycles", 64'(cyc), 256);
        check("t5_clean_evc", 64'(evc), 1);
        check("t5_clean_ebc", 64'(ebc), 4);

        // Small config: each vector held 4 cycles, 32-cycle sweep
        @(negedge clk) s_start = 1'b1;
        @(negedge clk) s_start = 1'b0;
        cyc = 0;
        bad = 0;
        while (!s_done && cyc < 200) begin
            if (s_pi != 3'(cyc / 4)) bad++;
            @(negedge clk);
            cyc++;
        end
        check("t6_cycles", 64'(cyc), 32);
        check("t6_pi_steps", 64'(bad), 0);
        check("t6_pi_final", 64'(s_pi), 7);
        check("t6_evc", 64'(s_evc), 6);
        check("t6_ebc", 64'(s_ebc), 8);
        check("t6_mae", 64'(s_mae), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
